// File: rtl/preg_ctrl_if.sv
// preg_ctrl_if: core, debug and preg-side signals of the picoMIPS register-file access controller.
interface preg_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] cpu_Rd, cpu_Rs, cpu_Rt;
    logic [DATA_WIDTH-1:0] cpu_Wdata;
    logic [1:0]            cpu_ctrl;
    logic                  cpu_stall;
    logic                  dbg_req, dbg_gnt, dbg_stb, dbg_we, dbg_ack;
    logic [ADDR_WIDTH-1:0] dbg_addr;
    logic [DATA_WIDTH-1:0] dbg_wdata, dbg_rdata;
    logic [ADDR_WIDTH-1:0] Rd, Rs, Rt;
    logic [DATA_WIDTH-1:0] Wdata, Rs_data;
    logic [1:0]            ctrl;
    modport slave (
        input  cpu_Rd, cpu_Rs, cpu_Rt, cpu_Wdata, cpu_ctrl,
        input  dbg_req, dbg_stb, dbg_we, dbg_addr, dbg_wdata, Rs_data,
        output cpu_stall, dbg_gnt, dbg_ack, dbg_rdata, Rd, Rs, Rt, Wdata, ctrl
    );
    modport master (
        output cpu_Rd, cpu_Rs, cpu_Rt, cpu_Wdata, cpu_ctrl,
        output dbg_req, dbg_stb, dbg_we, dbg_addr, dbg_wdata, Rs_data,
        input  cpu_stall, dbg_gnt, dbg_ack, dbg_rdata, Rd, Rs, Rt, Wdata, ctrl
    );
endinterface

// File: rtl/preg_ctrl.sv
// preg_ctrl: muxes preg between core and debug port; PREG_CTRL_CLEAR_EN adds a zero-clear after reset.
module preg_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic        clk,
    input  logic        nReset,
    preg_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
`ifdef PREG_CTRL_CLEAR_EN
        CLEAR,
`endif
        RUN, DBG_IDLE, DBG_ACK
    } state_t;
    state_t state, nxt;
    logic clr, run, dbg;
    logic [ADDR_WIDTH-1:0] clr_addr;
`ifdef PREG_CTRL_CLEAR_EN
    localparam state_t RST_STATE = CLEAR;
    localparam logic [ADDR_WIDTH:0] CLR_LAST = {1'b0, {ADDR_WIDTH{1'b1}}};
    logic [ADDR_WIDTH:0] clr_cnt;
    assign clr      = state == CLEAR;
    assign clr_addr = clr_cnt[ADDR_WIDTH-1:0];
`else
    localparam state_t RST_STATE = RUN;
    assign clr      = 1'b0;
    assign clr_addr = '0;
`endif
    assign run = state == RUN;
    assign dbg = state == DBG_IDLE || state == DBG_ACK;
    always_comb begin
        nxt = state;
        case (state)
`ifdef PREG_CTRL_CLEAR_EN
            CLEAR:    nxt = clr_cnt == CLR_LAST ? RUN : CLEAR;
`endif
            RUN:      nxt = bus.dbg_req && !bus.cpu_ctrl[0] ? DBG_IDLE : RUN;
            DBG_IDLE: nxt = bus.dbg_stb ? DBG_ACK : bus.dbg_req ? DBG_IDLE : RUN;
            default:  nxt = bus.dbg_req ? DBG_IDLE : RUN;
        endcase
    end
    // ctrl is forced idle while reset is held so no partial write reaches preg
    always_comb begin
        bus.Rd        = clr ? clr_addr : dbg ? bus.dbg_addr : bus.cpu_Rd;
        bus.Rs        = clr ? clr_addr : dbg ? bus.dbg_addr : bus.cpu_Rs;
        bus.Rt        = run ? bus.cpu_Rt : '0;
        bus.Wdata     = run ? bus.cpu_Wdata : clr ? '0 : bus.dbg_wdata;
        bus.ctrl      = !nReset ? 2'b00 : run ? bus.cpu_ctrl : clr ? 2'b01 :
                        state == DBG_IDLE ? {1'b0, bus.dbg_stb & bus.dbg_we} : 2'b00;
        bus.cpu_stall = !run;
    end
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state         <= RST_STATE;
            bus.dbg_gnt   <= 1'b0;
            bus.dbg_ack   <= 1'b0;
            bus.dbg_rdata <= '0;
`ifdef PREG_CTRL_CLEAR_EN
            clr_cnt       <= '0;
`endif
        end else begin
            state       <= nxt;
            bus.dbg_gnt <= nxt == DBG_IDLE || nxt == DBG_ACK;
            bus.dbg_ack <= nxt == DBG_ACK;
            if (state == DBG_IDLE && bus.dbg_stb)
                bus.dbg_rdata <= bus.dbg_we ? bus.dbg_wdata : bus.Rs_data;
`ifdef PREG_CTRL_CLEAR_EN
            if (clr)
                clr_cnt <= clr_cnt + 1'b1;
`endif
        end
    end
endmodule
